// File: rtl/execute_tv_pkg.sv
// ---------------------------------------------------------------------------
// execute_tv_pkg : shared widths, record packing and FSM states for the
//                  execute-stage test-vector recorder.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package execute_tv_pkg;

  localparam int PC_W  = 64;
  localparam int ALU_W = 64;
  localparam int WD_W  = 64;
  localparam int Z_W   = 1;
  localparam int REC_W = PC_W + ALU_W + WD_W + Z_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  function automatic logic [REC_W-1:0] pack_record(
    input logic [PC_W-1:0]  pc_branch,
    input logic [ALU_W-1:0] alu_result,
    input logic [WD_W-1:0]  write_data,
    input logic [Z_W-1:0]   zero
  );
    return {pc_branch, alu_result, write_data, zero};
  endfunction

endpackage

`default_nettype wire

// File: rtl/tv_buffer.sv
// ---------------------------------------------------------------------------
// tv_buffer : DEPTH x REC_W record store, one write port, async read port.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tv_buffer
  import execute_tv_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [REC_W-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [REC_W-1:0] o_rd_data
);

  // Contents are never reset; validity is tracked by the recorder's count.
  logic [REC_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/execute_tv_recorder.sv
// ---------------------------------------------------------------------------
// execute_tv_recorder : captures execute-stage outputs into a FIFO buffer,
//                       then drains them in capture order with ready/valid.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module execute_tv_recorder
  import execute_tv_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       capture_en,
  input  logic [PC_W-1:0]            PCBranch_E,
  input  logic [ALU_W-1:0]           aluResult_E,
  input  logic [WD_W-1:0]            writeData_E,
  input  logic                       zero_E,
  input  logic                       drain,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [REC_W-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE        = CW'(1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          w_capture;
  logic          w_wr_en;
  logic          w_xfer;

  assign count    = r_count;
  assign full     = (r_count == C_FULL_COUNT);
  assign empty    = (r_count == '0);
  assign overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    rd_valid    = 1'b0;
    done        = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_CAPTURE: begin
        w_capture = capture_en;
        if (drain) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        rd_valid = !reset && (r_count != '0);
        // Last record leaving, or nothing was captured at all.
        done = !reset && ((r_count == '0) || ((r_count == C_ONE) && rd_ready));
        if (done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = r_state;
    endcase
    if (start) begin
      w_state_nxt = ST_CAPTURE;
    end
  end

  assign w_wr_en = !reset && !start && w_capture && !full;
  assign w_xfer  = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (reset || start) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_count  <= r_count + 1'b1;
      end else if (w_xfer) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count  <= r_count - 1'b1;
      end
      if (w_capture && full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  tv_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (pack_record(PCBranch_E, aluResult_E, writeData_E, zero_E)),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (rd_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_execute_tv_recorder.sv
// ---------------------------------------------------------------------------
// tb_execute_tv_recorder : directed and random stimulus against a queue-based
//                          reference model of the recorder.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_execute_tv_recorder;
  import execute_tv_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int M_IDLE = 0, M_CAP = 1, M_DRAIN = 2;

  logic             clk = 1'b0;
  logic             reset, start, capture_en, drain, rd_ready, zero_E;
  logic [63:0]      PCBranch_E, aluResult_E, writeData_E;
  logic             rd_valid, full, empty, overflow, done;
  logic [REC_W-1:0] rd_data;
  logic [CW-1:0]    count;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of records plus mode and sticky overflow.
  logic [REC_W-1:0] q[$];
  int               mode = M_IDLE;
  logic             m_ovf = 1'b0;

  execute_tv_recorder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .capture_en(capture_en),
    .PCBranch_E(PCBranch_E), .aluResult_E(aluResult_E),
    .writeData_E(writeData_E), .zero_E(zero_E), .drain(drain),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [REC_W-1:0] obs, input logic [REC_W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] rnd_rec();
    return {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom),
            32'($urandom), 32'($urandom), 1'($urandom)};
  endfunction

  // One clock: drive, check at negedge, advance model, return at posedge+1.
  task automatic step(input logic s, input logic c, input logic d, input logic rr,
                      input logic [REC_W-1:0] rec, input logic rs);
    logic exp_rv, exp_done;
    int   sz;
    reset = rs; start = s; capture_en = c; drain = d; rd_ready = rr;
    {PCBranch_E, aluResult_E, writeData_E, zero_E} = rec;
    @(negedge clk);
    sz       = q.size();
    exp_rv   = !rs && mode == M_DRAIN && sz != 0;
    exp_done = !rs && mode == M_DRAIN && (sz == 0 || (sz == 1 && rr));
    chk("rd_valid", rd_valid, exp_rv);
    chk("done", done, exp_done);
    chk("count", count, sz);
    chk("full", full, sz == DEPTH);
    chk("empty", empty, sz == 0);
    chk("overflow", overflow, m_ovf);
    if (exp_rv) chk("rd_data", rd_data, q[0]);
    if (rs) begin
      q.delete(); mode = M_IDLE; m_ovf = 1'b0;
    end else if (s) begin
      q.delete(); mode = M_CAP; m_ovf = 1'b0;
    end else if (mode == M_CAP) begin
      if (c) begin
        if (sz < DEPTH) q.push_back(rec);
        else m_ovf = 1'b1;
      end
      if (d) mode = M_DRAIN;
    end else if (mode == M_DRAIN) begin
      if (exp_rv && rr) void'(q.pop_front());
      if (exp_done) mode = M_IDLE;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain_out();
    int guard = 0;
    while (mode == M_DRAIN && guard < 100) begin
      step(0, 0, 0, 1, rnd_rec(), 0);
      guard++;
    end
    chk("drain_budget", guard < 100, 1'b1);
  endtask

  initial begin
    reset = 1'b1; start = 0; capture_en = 0; drain = 0; rd_ready = 0;
    {PCBranch_E, aluResult_E, writeData_E, zero_E} = '0;
    repeat (2) @(posedge clk);
    #1;
    step(0, 1, 1, 1, rnd_rec(), 1);
    chk("reset_state", dut.r_state, ST_IDLE);

    // Three known records read back in order.
    step(1, 0, 0, 0, '0, 0);
    step(0, 1, 0, 0, pack_record(64'h10, 64'd1, 64'd0, 1'b0), 0);
    step(0, 1, 0, 0, pack_record(64'h20, 64'd2, 64'd0, 1'b0), 0);
    step(0, 1, 1, 0, pack_record(64'h30, 64'd3, 64'd0, 1'b1), 0);
    drain_out();
    chk("idle_after_drain", dut.r_state, ST_IDLE);
    step(0, 1, 1, 1, rnd_rec(), 0);

    // Overfill: only the first DEPTH records survive.
    step(1, 0, 0, 0, '0, 0);
    for (int i = 0; i < DEPTH + 2; i++) step(0, 1, 0, 0, rnd_rec(), 0);
    step(0, 0, 1, 0, '0, 0);
    drain_out();

    // Stalled readout with ready toggling.
    step(1, 0, 0, 0, '0, 0);
    step(0, 1, 0, 0, rnd_rec(), 0);
    step(0, 1, 1, 0, rnd_rec(), 0);
    step(0, 0, 0, 0, '0, 0);
    step(0, 0, 0, 1, '0, 0);
    step(0, 0, 0, 0, '0, 0);
    step(0, 0, 0, 1, '0, 0);
    chk("stall_idle", dut.r_state, ST_IDLE);

    // Drain with nothing captured.
    step(1, 0, 0, 0, '0, 0);
    step(0, 0, 1, 1, '0, 0);
    step(0, 1, 0, 1, rnd_rec(), 0);
    step(0, 1, 0, 1, rnd_rec(), 0);

    // Reset in the middle of a drain.
    step(1, 0, 0, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, rnd_rec(), 0);
    step(0, 0, 1, 0, '0, 0);
    step(0, 0, 0, 0, '0, 0);
    step(1, 0, 0, 1, '0, 1);
    step(0, 0, 0, 1, '0, 0);
    chk("reset_mid_drain", dut.r_state, ST_IDLE);

    // start+drain together, then capture+drain together.
    step(1, 0, 1, 0, '0, 0);
    step(0, 1, 1, 0, rnd_rec(), 0);
    drain_out();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 50,
           rnd_rec(), $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/execute_tv_recorder.md
EXECUTE_TV_RECORDER -- requirements
Module: execute_tv_recorder

Interface
REQ-001 Parameter DEPTH, default 16, is the number of records the buffer holds (power of two, >=2).
REQ-002 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  is the synchronous, active-high reset.
REQ-004 Port start  input  1  clears the buffer and enters capture mode.
REQ-005 Port capture_en  input  1  samples the execute-stage outputs this cycle.
REQ-006 Port PCBranch_E  input  64  is the execute-stage branch target.
REQ-007 Port aluResult_E  input  64  is the execute-stage ALU result.
REQ-008 Port writeData_E  input  64  is the execute-stage store data.
REQ-009 Port zero_E  input  1  is the execute-stage zero flag.
REQ-010 Port drain  input  1  ends capture and begins readout.
REQ-011 Port rd_ready  input  1  indicates the consumer accepts rd_data this cycle.
REQ-012 Port rd_valid  output  1  indicates rd_data holds a valid record.
REQ-013 Port rd_data  output  193  is the record {PCBranch_E, aluResult_E, writeData_E, zero_E}, MSB first.
REQ-014 Port count  output  $clog2(DEPTH+1)  is the number of stored records.
REQ-015 Port full, empty  output  1 each  reflect count==DEPTH and count==0.
REQ-016 Port overflow  output  1  is sticky; set when a capture is dropped.
REQ-017 Port done  output  1  is a one-cycle pulse when the last record is read out.

Function
REQ-018 The block SHALL implement states IDLE, CAPTURE, DRAIN.
REQ-019 In any state, start=1 SHALL clear wr_ptr, rd_ptr, count and overflow and enter CAPTURE next cycle; start has priority over drain and capture_en.
REQ-020 In CAPTURE, capture_en=1 with count<DEPTH SHALL write the 193-bit record at wr_ptr, increment wr_ptr (mod DEPTH) and count.
REQ-021 In CAPTURE, capture_en=1 with count==DEPTH SHALL leave the buffer unchanged and set overflow.
REQ-022 In CAPTURE, drain=1 SHALL enter DRAIN next cycle; a capture_en in the same cycle is still recorded.
REQ-023 capture_en SHALL be ignored in IDLE and DRAIN; drain SHALL be ignored outside CAPTURE.
REQ-024 In DRAIN, rd_valid SHALL equal (count!=0) and rd_data SHALL equal the record at rd_ptr, combinationally from stored state.
REQ-025 rd_data SHALL remain stable while rd_valid=1 and rd_ready=0.
REQ-026 A transfer occurs when rd_valid & rd_ready; it SHALL increment rd_ptr (mod DEPTH) and decrement count.
REQ-027 The transfer that brings count to 0 SHALL assert done that cycle and return to IDLE next cycle.
REQ-028 Entering DRAIN with count==0 SHALL assert done in the first DRAIN cycle and return to IDLE.
REQ-029 Records SHALL be read out in capture order (FIFO); rd_valid SHALL be 0 outside DRAIN.
REQ-030 Pointers SHALL wrap at DEPTH without affecting count.

Reset
REQ-031 reset=1 SHALL force IDLE, wr_ptr=0, rd_ptr=0, count=0, overflow=0, done=0, rd_valid=0, empty=1, full=0; reset overrides start.
REQ-032 Reset mid-CAPTURE or mid-DRAIN SHALL discard all records; buffer contents need not be cleared.

Structure
REQ-033 Package execute_tv_pkg SHALL hold REC_W=193, the record field widths and the state enum.
REQ-034 Storage SHALL be a sub-module tv_buffer (DEPTH x REC_W, one write port, one asynchronous read port).

Verification
REQ-035 start; capture 3 records (PCBranch=0x10,0x20,0x30, aluResult=1,2,3, writeData=0, zero=0,0,1); drain; rd_ready=1 -> three records in order, done with the third, count 3->0, state IDLE.
REQ-036 start; capture DEPTH+2 records -> full=1, count=DEPTH, overflow=1, drain returns first DEPTH records only.
REQ-037 DRAIN with 2 records, rd_ready toggling 0,1,0,1 -> rd_data stable while stalled, exactly 2 transfers, done on the 2nd.
REQ-038 start; drain immediately with count=0 -> done pulse in first DRAIN cycle, rd_valid never 1.
REQ-039 reset asserted during DRAIN with count=5 -> next cycle count=0, empty=1, rd_valid=0, IDLE.
REQ-040 start and drain same cycle -> CAPTURE entered, drain ignored, count=0; capture_en with drain in CAPTURE -> record stored, then DRAIN.
